// File: rtl/apb.sv
// Zero-wait-state APB slave in front of a small word-addressed register memory.
// Optional APB_SLVERR_EN: out-of-range addresses raise p_slverr instead of wrapping.
module apb #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 16
) (
    input  logic              p_clk,
    input  logic              p_reset,
    input  logic [31:0]       p_add,
    input  logic              p_sel,
    input  logic              p_enable,
    input  logic              p_write,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_ready,
    output logic              p_slverr,
    output logic [1:0]        ns
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              commit;

    // Word index wraps modulo the depth; in range it is simply p_add.
    assign idx    = IDX_W'(p_add % 32'(MEM_DEPTH));
    assign commit = (state == SETUP) && p_sel && p_enable;

`ifdef APB_SLVERR_EN
    logic err_q;

    assign in_range = (p_add < 32'(MEM_DEPTH));
    assign p_slverr = (state == ACCESS) && err_q;

    always_ff @(posedge p_clk or negedge p_reset) begin
        if (!p_reset) begin
            err_q <= 1'b0;
        end else if (commit) begin
            err_q <= !in_range;
        end
    end
`else
    assign in_range = 1'b1;
    assign p_slverr = 1'b0;
`endif

    always_comb begin
        // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
        next_state = IDLE;
        case (state)
            IDLE:    next_state = p_sel ? SETUP : IDLE;
            SETUP:   begin
                if (!p_sel)        next_state = IDLE;
                else if (p_enable) next_state = ACCESS;
                else               next_state = SETUP;
            end
            ACCESS:  next_state = p_sel ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign ns      = next_state;
    assign p_ready = (state == ACCESS);

    always_ff @(posedge p_clk or negedge p_reset) begin
        if (!p_reset) begin
            // NOTE: the register file is cleared on reset, so it must be flops rather than an inferred RAM.
            state   <= IDLE;
            p_rdata <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= next_state;
            if (commit) begin
                if (p_write) begin
                    if (in_range) mem[idx] <= p_wdata;
                end else begin
                    p_rdata <= in_range ? mem[idx] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb.sv
// Scoreboard bench for apb: tasks queue the expected ACCESS response, a negedge
// monitor pops and compares on every p_ready pulse.
module tb_apb;

    localparam int DATA_W = 32;

    logic              p_clk;
    logic              p_reset;
    logic [31:0]       p_add;
    logic              p_sel;
    logic              p_enable;
    logic              p_write;
    logic [DATA_W-1:0] p_wdata;
    logic [DATA_W-1:0] p_rdata;
    logic              p_ready;
    logic              p_slverr;
    logic [1:0]        ns;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   pulses   = 0;

    apb #(.DATA_W(DATA_W), .MEM_DEPTH(16)) dut (
        .p_clk    (p_clk),
        .p_reset  (p_reset),
        .p_add    (p_add),
        .p_sel    (p_sel),
        .p_enable (p_enable),
        .p_write  (p_write),
        .p_wdata  (p_wdata),
        .p_rdata  (p_rdata),
        .p_ready  (p_ready),
        .p_slverr (p_slverr),
        .ns       (ns)
    );

    initial begin
        p_clk = 1'b0;
        forever #5 p_clk = ~p_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ACCESS cycle must match the oldest queued expectation.
    always @(negedge p_clk) begin
        if (p_reset && p_ready) begin
            pulses++;
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(p_ready), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("access_rdata", p_rdata, e.rdata);
                check("access_slverr", 32'(p_slverr), 32'(e.slverr));
            end
        end
    end

    // One SETUP->ACCESS transfer; keep_sel leaves p_sel high for a back-to-back follow-up.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input logic keep_sel);
        exp_t e;
        p_sel    = 1'b1;
        p_enable = 1'b0;
        p_write  = wr;
        p_add    = addr;
        p_wdata  = wdata;
        #1 check("ns_to_setup", 32'(ns), 32'd1);
        @(posedge p_clk); #1;
        p_enable = 1'b1;
        #1 check("ns_to_access", 32'(ns), 32'd2);
        e.rdata  = exp_rd;
        e.slverr = exp_err;
        sb.push_back(e);
        pushed++;
        @(posedge p_clk); #1;
        p_enable = 1'b0;
        if (!keep_sel) begin
            p_sel = 1'b0;
            #1 check("ns_to_idle", 32'(ns), 32'd0);
            @(posedge p_clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        p_reset  = 1'b0;
        p_sel    = 1'b0;
        p_enable = 1'b0;
        p_write  = 1'b0;
        p_add    = '0;
        p_wdata  = '0;

        // Reset state
        #3;
        check("reset_rdata", p_rdata, 32'd0);
        check("reset_ready", 32'(p_ready), 32'd0);
        check("reset_slverr", 32'(p_slverr), 32'd0);
        check("reset_ns", 32'(ns), 32'd0);
        @(posedge p_clk); #1;
        p_reset = 1'b1;
        @(posedge p_clk); #1;

        // Write then read back; unwritten word reads zero
        xfer(1'b1, 32'd1, 32'd5, 32'd0, 1'b0, 1'b0);
        xfer(1'b0, 32'd1, 32'd0, 32'd5, 1'b0, 1'b0);
        xfer(1'b0, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);

        // Back-to-back writes (ACCESS->SETUP), then reads
        xfer(1'b1, 32'd2, 32'd7, 32'd0, 1'b0, 1'b1);
        xfer(1'b1, 32'd3, 32'd9, 32'd0, 1'b0, 1'b0);
        xfer(1'b0, 32'd2, 32'd0, 32'd7, 1'b0, 1'b1);
        xfer(1'b0, 32'd3, 32'd0, 32'd9, 1'b0, 1'b0);

        // p_enable in IDLE without p_sel is ignored
        p_enable = 1'b1;
        p_write  = 1'b1;
        p_add    = 32'd6;
        p_wdata  = 32'hDEAD;
        #1 check("idle_enable_ns", 32'(ns), 32'd0);
        @(posedge p_clk); #1;
        check("idle_enable_ready", 32'(p_ready), 32'd0);
        p_enable = 1'b0;
        xfer(1'b0, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0);

        // Out-of-range address 20 with depth 16
`ifdef APB_SLVERR_EN
        xfer(1'b1, 32'd20, 32'hAB, 32'd0, 1'b1, 1'b0);
        xfer(1'b0, 32'd4,  32'd0,  32'd0, 1'b0, 1'b0);
        xfer(1'b0, 32'd20, 32'd0,  32'd0, 1'b1, 1'b0);
`else
        xfer(1'b1, 32'd20, 32'hAB, 32'd0,  1'b0, 1'b0);
        xfer(1'b0, 32'd4,  32'd0,  32'hAB, 1'b0, 1'b0);
        xfer(1'b0, 32'd20, 32'd0,  32'hAB, 1'b0, 1'b0);
`endif
        xfer(1'b1, 32'd15, 32'h1234_5678, 32'hAB * 32'(`ifdef APB_SLVERR_EN 0 `else 1 `endif), 1'b0, 1'b0);
        xfer(1'b0, 32'd15, 32'd0, 32'h1234_5678, 1'b0, 1'b0);

        // Reset asserted in SETUP with enable high aborts the transfer
        p_sel    = 1'b1;
        p_write  = 1'b1;
        p_add    = 32'd5;
        p_wdata  = 32'h55;
        @(posedge p_clk); #1;
        p_enable = 1'b1;
        #1 check("abort_ns_pre", 32'(ns), 32'd2);
        p_reset = 1'b0;
        #1;
        p_sel    = 1'b0;
        p_enable = 1'b0;
        #1;
        check("abort_ns", 32'(ns), 32'd0);
        check("abort_ready", 32'(p_ready), 32'd0);
        check("abort_rdata", p_rdata, 32'd0);
        @(posedge p_clk); #1;
        p_reset = 1'b1;
        @(posedge p_clk); #1;
        xfer(1'b0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        xfer(1'b0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);

        repeat (3) @(posedge p_clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("ready_pulses", 32'(pulses), 32'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
